// File: rtl/uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder
//
// Byte-level command responder that sits on the FIFO side of a UART core.
// It pops framed host commands (HDR, CMD, ADDR, [DATA], CHK) from the Rx
// FIFO and validates them. It then executes register writes and reads on
// an internal register bank and pushes ACK/NAK response frames into the
// Tx FIFO.
//
// Ports:
//   clk_100MHz  in   system clock
//   reset       in   synchronous, active-high reset
//   rx_empty    in   Rx FIFO empty flag
//   rx_data     in   Rx FIFO head word, valid while rx_empty=0
//   rx_pop      out  one-cycle pop strobe to the Rx FIFO
//   tx_full     in   Tx FIFO full flag
//   tx_data     out  byte to the Tx FIFO, valid while tx_push=1
//   tx_push     out  one-cycle push strobe to the Tx FIFO
//   reg_out     out  flattened register bank, reg k at [8k+7:8k]
//   err_cnt     out  saturating count of NAKs plus timeouts
//   busy        out  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module uart_cmd_responder #(
    parameter int               DBITS       = 8,
    parameter int               NREGS       = 8,
    parameter logic [DBITS-1:0] HDR         = 8'hA5,
    parameter int               TIMEOUT_CYC = 1_000_000,
    parameter int               TO_BITS     = 20
) (
    input  logic                   clk_100MHz,
    input  logic                   reset,
    input  logic                   rx_empty,
    input  logic [DBITS-1:0]       rx_data,
    output logic                   rx_pop,
    input  logic                   tx_full,
    output logic [DBITS-1:0]       tx_data,
    output logic                   tx_push,
    output logic [NREGS*DBITS-1:0] reg_out,
    output logic [7:0]             err_cnt,
    output logic                   busy
);

    localparam int               AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [DBITS-1:0] CMD_WR  = DBITS'(8'h57);
    localparam logic [DBITS-1:0] CMD_RD  = DBITS'(8'h52);
    localparam logic [DBITS-1:0] ACK     = DBITS'(8'h06);
    localparam logic [DBITS-1:0] NAK     = DBITS'(8'h15);
    localparam logic [DBITS-1:0] NREGS_B = DBITS'(NREGS);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_CMD,
        S_GET_ADDR,
        S_GET_DATA,
        S_GET_CHK,
        S_EXEC,
        S_SEND
    } state_t;

    state_t             state_q, state_d;
    logic [DBITS-1:0]   cmd_q, cmd_d;
    logic [DBITS-1:0]   addr_q, addr_d;
    logic [DBITS-1:0]   data_q, data_d;
    logic [DBITS-1:0]   chk_q, chk_d;
    logic [DBITS-1:0]   reply_q, reply_d;
    logic               ack_q, ack_d;
    logic               rd_resp_q, rd_resp_d;
    logic [1:0]         idx_q, idx_d;
    logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]         err_q, err_d;
    logic [DBITS-1:0]   regs_q [NREGS];
    logic [DBITS-1:0]   regs_d [NREGS];

    logic               frame_ok;
    logic [AW-1:0]      reg_idx;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Frame validity is judged purely from the captured bytes. data_q is
    // cleared for non-write commands, so the same XOR covers both formats.
    assign reg_idx  = addr_q[AW-1:0];
    assign frame_ok = ((cmd_q == CMD_WR) || (cmd_q == CMD_RD)) &&
                      (addr_q < NREGS_B) &&
                      (chk_q == (cmd_q ^ addr_q ^ data_q));

    // Next-state and output logic. Strobes are gated by reset so that nothing
    // is popped or pushed in a reset cycle, even mid-response.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        chk_d     = chk_q;
        reply_d   = reply_q;
        ack_d     = ack_q;
        rd_resp_d = rd_resp_q;
        idx_d     = idx_q;
        to_cnt_d  = '0;
        err_d     = err_q;
        regs_d    = regs_q;
        rx_pop    = 1'b0;
        tx_push   = 1'b0;
        tx_data   = '0;

        case (state_q)
            S_IDLE: begin
                if (!rx_empty) begin
                    rx_pop = 1'b1;
                    if (rx_data == HDR) begin
                        state_d = S_GET_CMD;
                    end
                end
            end

            S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK: begin
                if (!rx_empty) begin
                    rx_pop = 1'b1;
                    case (state_q)
                        S_GET_CMD: begin
                            cmd_d   = rx_data;
                            state_d = S_GET_ADDR;
                        end
                        S_GET_ADDR: begin
                            addr_d = rx_data;
                            if (cmd_q == CMD_WR) begin
                                state_d = S_GET_DATA;
                            end else begin
                                data_d  = '0;
                                state_d = S_GET_CHK;
                            end
                        end
                        S_GET_DATA: begin
                            data_d  = rx_data;
                            state_d = S_GET_CHK;
                        end
                        default: begin
                            chk_d   = rx_data;
                            state_d = S_EXEC;
                        end
                    endcase
                end else if (to_cnt_q == TO_LAST) begin
                    // Host went silent mid-frame: drop it without replying.
                    err_d   = sat_inc(err_q);
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            S_EXEC: begin
                ack_d     = frame_ok;
                rd_resp_d = frame_ok && (cmd_q == CMD_RD);
                idx_d     = 2'd0;
                state_d   = S_SEND;
                if (!frame_ok) begin
                    err_d = sat_inc(err_q);
                end else if (cmd_q == CMD_WR) begin
                    regs_d[reg_idx] = data_q;
                end else begin
                    reply_d = regs_q[reg_idx];
                end
            end

            S_SEND: begin
                case (idx_q)
                    2'd0:    tx_data = HDR;
                    2'd1:    tx_data = ack_q ? ACK : NAK;
                    default: tx_data = reply_q;
                endcase
                if (!tx_full) begin
                    tx_push = 1'b1;
                    if (idx_q == (rd_resp_q ? 2'd2 : 2'd1)) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (reset) begin
            rx_pop  = 1'b0;
            tx_push = 1'b0;
            tx_data = '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            chk_q     <= '0;
            reply_q   <= '0;
            ack_q     <= 1'b0;
            rd_resp_q <= 1'b0;
            idx_q     <= 2'd0;
            to_cnt_q  <= '0;
            err_q     <= 8'd0;
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            chk_q     <= chk_d;
            reply_q   <= reply_d;
            ack_q     <= ack_d;
            rd_resp_q <= rd_resp_d;
            idx_q     <= idx_d;
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_reg_out
        assign reg_out[k*DBITS +: DBITS] = regs_q[k];
    end

    assign err_cnt = err_q;
    assign busy    = (state_q != S_IDLE);

endmodule
